sram_like_responder: RTL and testbench

- Memory-side responder for the CPU's sram-like request interface (req/addr_ok/data_ok), serving one instruction or data port from an internal word array.
- Used in simulation and standalone SoC builds in place of the AXI bridge.
- Accepts one request at a time, answers after a programmable latency, and commits byte/half/word writes with lane enables derived from size and address.

---
 rtl/sram_like_responder_if.sv | 23 ++
 rtl/sram_like_responder.sv | 116 +++++++++++
 tb/tb_sram_like_responder.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/sram_like_responder_if.sv
// Sram-like request/response bundle between a CPU port and a memory responder.
// The CPU side drives the request; the memory side answers with addr_ok/data_ok.
interface sram_like_responder_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, wr, size, addr, wdata,
        input  addr_ok, data_ok, rdata, err
    );

    modport slave (
        input  req, wr, size, addr, wdata,
        output addr_ok, data_ok, rdata, err
    );
endinterface

// File: rtl/sram_like_responder.sv
// Sram-like memory responder: one outstanding request, fixed response latency,
// byte/half/word writes with lane enables, aligned-word reads with error flag.
module sram_like_responder #(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  resetn,
    sram_like_responder_if.slave  bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    state_e       state_q;
    logic [3:0]   cnt_q;
    logic [31:0]  pend_q;
    logic         pend_err_q;
    logic [31:0]  rdata_q;
    logic         err_q;
    logic         data_ok_q;

    logic [31:0]  mem_q [DEPTH];

    logic                  accept;
    logic                  bad;
    logic [3:0]            be;
    logic [DEPTH_LOG2-1:0] idx;
    logic [31:0]           resp_d;
    logic                  unused_hi;

    assign bus.addr_ok = resetn && (state_q == IDLE || state_q == RESP);
    assign accept      = bus.req && bus.addr_ok;
    assign idx         = bus.addr[DEPTH_LOG2+1:2];
    assign unused_hi   = ^bus.addr[31:DEPTH_LOG2+2];

    always_comb begin
        be  = 4'b0000;
        bad = 1'b0;
        unique case (bus.size)
            2'd0: be = 4'b0001 << bus.addr[1:0];
            2'd1: begin
                bad = bus.addr[0];
                be  = bus.addr[1] ? 4'b1100 : 4'b0011;
            end
            2'd2: begin
                bad = |bus.addr[1:0];
                be  = 4'b1111;
            end
            default: bad = 1'b1;
        endcase
        if (bad) be = 4'b0000;
    end

    // Writes and errored requests answer with a zero word.
    assign resp_d = (bus.wr || bad) ? 32'h0 : mem_q[idx];

    always_ff @(posedge clk) begin
        if (accept && bus.wr) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem_q[idx][8*b +: 8] <= bus.wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            pend_q     <= 32'h0;
            pend_err_q <= 1'b0;
            rdata_q    <= 32'h0;
            err_q      <= 1'b0;
            data_ok_q  <= 1'b0;
        end else begin
            data_ok_q <= 1'b0;
            err_q     <= 1'b0;
            unique case (state_q)
                IDLE, RESP: begin
                    if (!accept) begin
                        state_q <= IDLE;
                    end else if (LATENCY > 1) begin
                        state_q    <= WAIT;
                        cnt_q      <= CNT_LOAD;
                        pend_q     <= resp_d;
                        pend_err_q <= bad;
                    end else begin
                        state_q   <= RESP;
                        rdata_q   <= resp_d;
                        err_q     <= bad;
                        data_ok_q <= 1'b1;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q   <= RESP;
                        rdata_q   <= pend_q;
                        err_q     <= pend_err_q;
                        data_ok_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.data_ok = data_ok_q;
    assign bus.rdata   = rdata_q;
    assign bus.err     = err_q;
endmodule

// File: tb/tb_sram_like_responder.sv
// Randomized bench for sram_like_responder against a byte-level memory model,
// with three instances at latencies 2, 1 and 4.
module tb_sram_like_responder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]        rstn_a;
    logic [2:0]        req_a;
    logic [2:0]        wr_a;
    logic [2:0][1:0]   size_a;
    logic [2:0][31:0]  addr_a;
    logic [2:0][31:0]  wdata_a;
    wire  [2:0]        aok;
    wire  [2:0]        dok;
    wire  [2:0]        er;
    wire  [2:0][31:0]  rd;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] ref_b [3][4096];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        sram_like_responder_if bus ();
        assign bus.req   = req_a[g];
        assign bus.wr    = wr_a[g];
        assign bus.size  = size_a[g];
        assign bus.addr  = addr_a[g];
        assign bus.wdata = wdata_a[g];
        assign aok[g]    = bus.addr_ok;
        assign dok[g]    = bus.data_ok;
        assign er[g]     = bus.err;
        assign rd[g]     = bus.rdata;
        sram_like_responder #(
            .DEPTH_LOG2 (10),
            .LATENCY    (g == 0 ? 2 : (g == 1 ? 1 : 4))
        ) u_dut (
            .clk    (clk),
            .resetn (rstn_a[g]),
            .bus    (bus.slave)
        );
    end

    function automatic int lat_of(input int k);
        return k == 0 ? 2 : (k == 1 ? 1 : 4);
    endfunction

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input int k,
                                             input logic [31:0] a);
        logic [11:0] base;
        base = {a[11:2], 2'b00};
        return {ref_b[k][base + 12'd3], ref_b[k][base + 12'd2],
                ref_b[k][base + 12'd1], ref_b[k][base]};
    endfunction

    // Memory seen as 4 KiB of bytes; higher address bits alias away.
    task automatic model(input int k, input logic w,
                         input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] wd,
                         output logic [31:0] ed, output logic ee);
        int nb;
        logic [11:0] ba;
        nb = 1 << sz;
        ee = (sz == 2'd3) || ((int'(a[1:0]) % nb) != 0);
        ed = 32'h0;
        if (!ee) begin
            if (w) begin
                for (int i = 0; i < nb; i++) begin
                    ba = a[11:0] + 12'(i);
                    ref_b[k][ba] = wd[8*ba[1:0] +: 8];
                end
            end else begin
                ed = ref_word(k, a);
            end
        end
    endtask

    task automatic do_txn(input int k, input logic w,
                          input logic [1:0] sz, input logic [31:0] a,
                          input logic [31:0] wd,
                          output logic [31:0] got);
        logic [31:0] exp_d;
        logic exp_e;
        int n;
        model(k, w, sz, a, wd, exp_d, exp_e);
        @(negedge clk);
        req_a[k]   = 1'b1;
        wr_a[k]    = w;
        size_a[k]  = sz;
        addr_a[k]  = a;
        wdata_a[k] = wd;
        n = 0;
        while (!aok[k] && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("addr_ok", 32'(aok[k]), 32'd1);
        @(posedge clk);
        #1;
        req_a[k] = 1'b0;
        n = 1;
        while (!dok[k] && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("latency", n, lat_of(k));
        check("err", 32'(er[k]), 32'(exp_e));
        check("rdata", rd[k], exp_d);
        got = rd[k];
    endtask

    initial begin
        logic [31:0] g;
        logic [31:0] a;
        logic [1:0]  sz;
        int hits;

        rstn_a  = '1;
        req_a   = '0;
        wr_a    = '0;
        size_a  = '0;
        addr_a  = '0;
        wdata_a = '0;
        #1 rstn_a = '0;

        repeat (3) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                check("rst_aok", 32'(aok[k]), 32'd0);
                check("rst_dok", 32'(dok[k]), 32'd0);
                check("rst_rd", rd[k], 32'h0);
                check("rst_err", 32'(er[k]), 32'd0);
            end
        end
        rstn_a = '1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check("idle_aok", 32'(aok[k]), 32'd1);
            check("idle_dok", 32'(dok[k]), 32'd0);
        end

        do_txn(0, 1'b1, 2'd2, 32'h40, 32'hDEADBEEF, g);
        do_txn(0, 1'b0, 2'd2, 32'h40, 32'h0, g);
        check("word_rd", g, 32'hDEADBEEF);
        do_txn(0, 1'b1, 2'd0, 32'h41, 32'h0000AA00, g);
        do_txn(0, 1'b1, 2'd1, 32'h42, 32'h12340000, g);
        do_txn(0, 1'b0, 2'd2, 32'h40, 32'h0, g);
        check("partial", g, 32'h1234AAEF);
        do_txn(0, 1'b1, 2'd2, 32'h42, 32'hFFFFFFFF, g);
        check("mis_err", 32'(er[0]), 32'd1);
        do_txn(0, 1'b0, 2'd2, 32'h40, 32'h0, g);
        check("unchanged", g, 32'h1234AAEF);
        do_txn(0, 1'b0, 2'd3, 32'h40, 32'h0, g);
        check("ill_err", 32'(er[0]), 32'd1);
        check("ill_rd", g, 32'h0);

        for (int k = 0; k < 3; k++) begin
            for (int w = 0; w < 16; w++) begin
                a = ($urandom << 12) | 32'(w * 4);
                do_txn(k, 1'b1, 2'd2, a, $urandom, g);
            end
            for (int t = 0; t < 40; t++) begin
                a  = ($urandom << 12) | 32'($urandom_range(0, 63));
                sz = 2'($urandom_range(0, 3));
                do_txn(k, 1'($urandom), sz, a, $urandom, g);
            end
        end

        @(negedge clk);
        req_a[1]  = 1'b1;
        wr_a[1]   = 1'b0;
        size_a[1] = 2'd2;
        addr_a[1] = 32'h0;
        for (int i = 0; i < 4; i++) begin
            check("b2b_aok", 32'(aok[1]), 32'd1);
            @(posedge clk);
            #1;
            check("b2b_dok", 32'(dok[1]), 32'd1);
            check("b2b_rd", rd[1], ref_word(1, 32'(i * 4)));
            if (i < 3) addr_a[1] = 32'((i + 1) * 4);
            else req_a[1] = 1'b0;
        end

        do_txn(2, 1'b1, 2'd2, 32'h1000, 32'hCAFE1234, g);
        do_txn(2, 1'b0, 2'd2, 32'h0, 32'h0, g);
        check("alias", g, 32'hCAFE1234);

        @(negedge clk);
        req_a[2]  = 1'b1;
        wr_a[2]   = 1'b0;
        size_a[2] = 2'd2;
        addr_a[2] = 32'h0;
        check("mid_aok", 32'(aok[2]), 32'd1);
        @(posedge clk);
        #1;
        req_a[2] = 1'b0;
        hits = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (dok[2]) hits++;
        end
        rstn_a[2] = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (dok[2]) hits++;
        end
        check("mid_rst_rd", rd[2], 32'h0);
        rstn_a[2] = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (dok[2]) hits++;
        end
        check("mid_dropped", hits, 0);
        do_txn(2, 1'b0, 2'd2, 32'h0, 32'h0, g);
        check("mid_kept", g, 32'hCAFE1234);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
